// File: rtl/repeat_updown_counter.sv
// repeat_updown_counter
//   Push-button driven up/down counter for the 8-digit display path. The raw
//   button is synchronised, debounced and edge-detected. Holding the button
//   auto-repeats after an initial delay. The counter is DIGITS nibbles wide,
//   counts in BCD or binary, and either wraps or saturates at its limits.
//
//   Ports
//     clk      system clock
//     rst      asynchronous active-high reset
//     inc      raw push-button, active high (asynchronous)
//     uphdnl   raw direction switch, 1 = up, 0 = down (asynchronous)
//     clr      synchronous clear, clk domain; wins over a coincident step
//     q        counter value, 4*DIGITS bits, digit 0 in q[3:0]
//     step     one-cycle pulse per accepted step request (also when saturated)
//     wrapped  one-cycle pulse when a step wrapped the counter

// Per-digit step logic. It is purely combinational.
//   at_lim : this digit is at the value that carries (up) or borrows (down).
//   d_nxt  : digit value after the step, given the carry/borrow in (cin).
module repeat_updown_digit #(
  parameter bit BCD = 1'b1
) (
  input  logic [3:0] d,
  input  logic       up,
  input  logic       cin,
  output logic       at_lim,
  output logic [3:0] d_nxt
);
  localparam logic [3:0] MAX = BCD ? 4'd9 : 4'd15;

  // >= rather than == so that an out-of-range BCD nibble rolls back to 0.
  assign at_lim = up ? (d >= MAX) : (d == 4'd0);

  always_comb begin
    d_nxt = d;
    if (cin) begin
      if (up) d_nxt = at_lim ? 4'd0 : d + 4'd1;
      else    d_nxt = at_lim ? MAX  : d - 4'd1;
    end
  end
endmodule

module repeat_updown_counter #(
  parameter int DIGITS       = 8,
  parameter int DEB_CYCLES   = 500000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000,
  parameter bit WRAP         = 1'b1,
  parameter bit BCD          = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  uphdnl,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   q,
  output logic                  step,
  output logic                  wrapped
);
  // deb_cnt only has to reach DEB_CYCLES-1. The timer only has to hold the
  // larger reload value.
  localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LD = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LD  = TW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // ---------------------------------------------------------------- sync
  logic [1:0] inc_sync, dir_sync;
  logic       s_inc, dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_sync <= '0;
      dir_sync <= '0;
    end else begin
      inc_sync <= {inc_sync[0], inc};
      dir_sync <= {dir_sync[0], uphdnl};
    end
  end

  assign s_inc = inc_sync[1];
  assign dir   = dir_sync[1];

  // ------------------------------------------------------------ debounce
  // deb follows s_inc only after DEB_CYCLES consecutive mismatching cycles.
  // Any return to agreement restarts the count.
  logic          deb, deb_d;
  logic [DW-1:0] deb_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      deb_d <= deb;
      if (s_inc != deb) begin
        if (deb_cnt == DEB_LAST) begin
          deb     <= ~deb;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------- repeat FSM
  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    req       = 1'b0;
    case (state)
      IDLE: begin
        if (deb && !deb_d) begin
          req       = 1'b1;
          timer_nxt = DELAY_LD;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!deb) begin
          state_nxt = IDLE;
        end else if (timer == '0) begin
          req       = 1'b1;
          timer_nxt = RATE_LD;
          state_nxt = REPEAT;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      REPEAT: begin
        if (!deb) begin
          state_nxt = IDLE;
        end else if (timer == '0) begin
          req       = 1'b1;
          timer_nxt = RATE_LD;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------- counter
  logic [DIGITS-1:0][3:0] q_r, d_nxt;
  logic [DIGITS-1:0]      at_lim;
  logic [DIGITS:0]        carry;
  logic                   overflow;

  // The carry into digit i is set when every lower digit is at its limit.
  // The carry out of the top digit means the whole value was at max (up) or
  // at zero (down).
  always_comb begin
    carry[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) carry[i+1] = carry[i] & at_lim[i];
  end

  assign overflow = carry[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    repeat_updown_digit #(.BCD(BCD)) u_dig (
      .d      (q_r[i]),
      .up     (dir),
      .cin    (carry[i]),
      .at_lim (at_lim[i]),
      .d_nxt  (d_nxt[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r     <= '0;
      step    <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      step    <= 1'b0;
      wrapped <= 1'b0;
      if (clr) begin
        q_r <= '0;
      end else if (req) begin
        step <= 1'b1;
        // When saturating, a step at the limit is acknowledged but leaves q.
        if (!overflow || WRAP) q_r <= d_nxt;
        wrapped <= overflow && WRAP;
      end
    end
  end

  assign q = q_r;
endmodule
